fec_stream_decoder: RTL and testbench
=====================================

FEC_STREAM_DECODER -- requirements
Module: fec_stream_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning data bits per row; legal range is 2 or more.
REQ-002 SHALL have parameter DEPTH, default 4, meaning rows per block; legal range is 2 or more.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the width of each statistics counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: an input row beat is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a row beat.
REQ-008 SHALL have port in_data, input, WIDTH bits: one data row.
REQ-009 SHALL have port in_row_par, input, 1 bit: the received even-parity bit for this row.
REQ-010 SHALL have port in_col_par, input, WIDTH bits: the received column parity, sampled only on the DEPTH-th beat.
REQ-011 SHALL have port out_valid, input/output pair out_valid (output, 1 bit) and out_ready (input, 1 bit): the output row handshake.
REQ-012 SHALL have port out_data, output, WIDTH bits: a corrected row.
REQ-013 SHALL have port out_last, output, 1 bit: marks the final row (DEPTH-1) of a block.
REQ-014 SHALL have ports err_det, err_corr and err_uncorr, outputs, 1 bit each: block status, valid whenever out_valid=1.
REQ-015 SHALL have ports err_row ($clog2(DEPTH) bits) and err_col ($clog2(WIDTH) bits), outputs: the location of a corrected data bit, otherwise 0.

Function
REQ-016 SHALL use even parity: row i syndrome = XOR(row i bits, row_par i); column j syndrome = XOR(column j over all rows, col_par j).
REQ-017 SHALL accumulate syndromes incrementally as beats arrive and buffer the DEPTH rows internally.
REQ-018 SHALL implement FSM S_LOAD, then S_EVAL, then S_DRAIN, then back to S_LOAD.
REQ-019 SHALL set in_ready=1 only in S_LOAD and count accepted beats 0..DEPTH-1.
REQ-020 SHALL move to S_EVAL on acceptance of beat DEPTH-1.
REQ-021 SHALL spend exactly one cycle in S_EVAL, registering the classification; out_valid rises on the 2nd clock edge after the last input accept.
REQ-022 SHALL classify the zero syndrome as: err_det=0, err_corr=0, err_uncorr=0.
REQ-023 SHALL classify exactly one row-syndrome bit (r) and exactly one column-syndrome bit (c) as: flip data[r][c], err_det=1, err_corr=1, err_row=r, err_col=c.
REQ-024 SHALL classify exactly one syndrome bit set, in row or column only (a parity-bit error), as: data unchanged, err_det=1, err_corr=1.
REQ-025 SHALL classify any other nonzero syndrome as: data unchanged, err_det=1, err_uncorr=1.
REQ-026 SHALL in S_DRAIN emit rows 0..DEPTH-1 in order, one per out_valid&&out_ready cycle, with out_last=1 on row DEPTH-1.
REQ-027 SHALL hold out_data, out_last and status stable while out_valid=1 and out_ready=0.
REQ-028 SHALL on the final output handshake return to S_LOAD and clear the syndromes and beat counter.
REQ-029 SHALL make in_ready=1 in the cycle after that final output handshake.
REQ-030 SHALL ignore in_col_par on all beats except beat DEPTH-1, and ignore in_* whenever in_ready=0.

Reset
REQ-031 SHALL on rst=1 at a clock edge enter S_LOAD and clear the beat counter, syndromes, and row buffer.
REQ-032 SHALL drive outputs during and after reset as: in_ready=1 after reset, with out_valid=0, out_last=0, out_data=0, all err_* outputs=0, err_row=0, err_col=0, and statistics counters=0.
REQ-033 SHALL on reset mid-block (S_LOAD, S_EVAL or S_DRAIN) discard the partial block, with no output beats following.

Configuration
REQ-034 SHALL provide macro FEC_DEC_STATS_EN; when defined it adds input clr_stats (1 bit) and outputs cnt_corr and cnt_uncorr (CNT_W bits each).
REQ-035 SHALL with FEC_DEC_STATS_EN defined increment cnt_corr or cnt_uncorr by 1 per block in the S_EVAL cycle according to class.
REQ-036 SHALL saturate the counters at all-ones; clr_stats=1 zeroes both the next cycle and wins over a simultaneous increment.
REQ-037 SHALL without FEC_DEC_STATS_EN omit those ports and the counter logic entirely, with all other behaviour identical.

Structure
REQ-038 SHALL place the FSM state enum, a status struct {det, corr, uncorr}, and a popcount-is-one function in shared package fec_pkg.
REQ-039 SHALL implement the syndrome-to-class/location logic as combinational sub-module fec_syn_classify.

Verification (WIDTH=4, DEPTH=4; rows listed r0..r3)
REQ-040 SHALL cover: rows 1111,1111,1111,1111, row_par 0000, col_par 0000 -> no err flags, output equals input, out_last on r3.
REQ-041 SHALL cover: rows 1111,1111,1111,1110, par 0/0 -> err_corr=1, err_row=3, err_col=0, output all 1111.
REQ-042 SHALL cover: rows all 1111, row_par 0010, col_par 0000 -> err_det=1, err_corr=1, data unchanged.
REQ-043 SHALL cover: rows 0111,1011,1101,1110, par 0/0 -> err_uncorr=1, data unchanged, cnt_uncorr +1 (STATS_EN).
REQ-044 SHALL cover: out_ready low 3 cycles during r1 -> r1 held stable, in_ready=0 throughout, then next block accepted immediately after r3.
REQ-045 SHALL cover: CNT_W=2, five correctable blocks -> cnt_corr=3 (saturated); clr_stats coincident with 6th -> cnt_corr=0; rst during S_DRAIN -> out_valid=0 next cycle.

Source files
------------

// File: rtl/fec_pkg.sv
// fec_pkg: FSM states, block status type and a one-hot test shared by the FEC decoder files
package fec_pkg;
   typedef enum logic [1:0] {S_LOAD, S_EVAL, S_DRAIN} state_t;
   typedef struct packed {
      logic det;
      logic corr;
      logic uncorr;
   } status_t;
   function automatic logic pop_is_one(input logic [31:0] v);
      return v != '0 && (v & (v - 32'd1)) == '0;
   endfunction
endpackage

// File: rtl/fec_stream_decoder_if.sv
// fec_stream_decoder_if: row input stream, corrected row output stream and block status
interface fec_stream_decoder_if #(parameter int WIDTH = 4, parameter int DEPTH = 4);
   logic in_valid, in_ready, in_row_par, out_valid, out_ready, out_last;
   logic err_det, err_corr, err_uncorr;
   logic [WIDTH-1:0] in_data, in_col_par, out_data;
   logic [$clog2(DEPTH)-1:0] err_row;
   logic [$clog2(WIDTH)-1:0] err_col;
   modport master (
      output in_valid, in_data, in_row_par, in_col_par, out_ready,
      input in_ready, out_valid, out_data, out_last, err_det, err_corr, err_uncorr, err_row, err_col
   );
   modport slave (
      input in_valid, in_data, in_row_par, in_col_par, out_ready,
      output in_ready, out_valid, out_data, out_last, err_det, err_corr, err_uncorr, err_row, err_col
   );
endinterface

// File: rtl/fec_syn_classify.sv
// fec_syn_classify: maps row/column syndromes to block status and the data bit to flip
module fec_syn_classify
   import fec_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic [DEPTH-1:0]         row_syn,
   input  logic [WIDTH-1:0]         col_syn,
   output status_t                  st,
   output logic                     flip,
   output logic [$clog2(DEPTH)-1:0] row,
   output logic [$clog2(WIDTH)-1:0] col
);
   localparam int RW = $clog2(DEPTH);
   localparam int CW = $clog2(WIDTH);
   logic row_one, col_one, row_zero, col_zero;
   logic [RW-1:0] r;
   logic [CW-1:0] c;
   always_comb begin
      r = '0;
      c = '0;
      for (int i = 0; i < DEPTH; i++) if (row_syn[i]) r = RW'(i);
      for (int j = 0; j < WIDTH; j++) if (col_syn[j]) c = CW'(j);
   end
   assign row_one = pop_is_one(32'(row_syn));
   assign col_one = pop_is_one(32'(col_syn));
   assign row_zero = row_syn == '0;
   assign col_zero = col_syn == '0;
   assign flip = row_one && col_one;
   assign st.det = !(row_zero && col_zero);
   // a lone row or column syndrome bit means the parity bit itself was hit
   assign st.corr = flip || (row_one && col_zero) || (row_zero && col_one);
   assign st.uncorr = st.det && !st.corr;
   assign row = flip ? r : '0;
   assign col = flip ? c : '0;
endmodule

// File: rtl/fec_stream_decoder.sv
// fec_stream_decoder: 2-D parity block decoder with single-bit correction; FEC_DEC_STATS_EN adds block counters
module fec_stream_decoder
   import fec_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic clk,
   input  logic rst,
`ifdef FEC_DEC_STATS_EN
   input  logic             clr_stats,
   output logic [CNT_W-1:0] cnt_corr,
   output logic [CNT_W-1:0] cnt_uncorr,
`endif
   fec_stream_decoder_if.slave bus
);
   localparam int RW = $clog2(DEPTH);
   localparam int CW = $clog2(WIDTH);
   state_t state, state_n;
   logic [RW-1:0] cnt, er, er_c;
   logic [CW-1:0] ec, ec_c;
   logic [WIDTH-1:0] rows [DEPTH];
   logic [DEPTH-1:0] row_syn;
   logic [WIDTH-1:0] col_syn;
   status_t st, st_c;
   logic flip, last, acc, take, fin;
   fec_syn_classify #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_classify (
      .row_syn(row_syn),
      .col_syn(col_syn),
      .st(st_c),
      .flip(flip),
      .row(er_c),
      .col(ec_c)
   );
   assign last = cnt == RW'(DEPTH - 1);
   assign acc = state == S_LOAD && bus.in_valid;
   assign take = state == S_DRAIN && bus.out_ready;
   assign fin = take && last;
   always_comb begin
      state_n = state;
      if (acc && last) state_n = S_EVAL;
      if (state == S_EVAL) state_n = S_DRAIN;
      if (fin) state_n = S_LOAD;
   end
   always_ff @(posedge clk)
      if (rst) begin
         state <= S_LOAD;
         cnt <= '0;
         row_syn <= '0;
         col_syn <= '0;
         st <= '0;
         er <= '0;
         ec <= '0;
         for (int i = 0; i < DEPTH; i++) rows[i] <= '0;
      end else begin
         state <= state_n;
         if (acc) begin
            rows[cnt] <= bus.in_data;
            row_syn[cnt] <= ^bus.in_data ^ bus.in_row_par;
            col_syn <= col_syn ^ bus.in_data ^ (last ? bus.in_col_par : '0);
         end
         if (acc || take) cnt <= last ? '0 : cnt + 1'b1;
         // correction is applied in place so draining just reads the buffer
         if (state == S_EVAL) begin
            st <= st_c;
            er <= er_c;
            ec <= ec_c;
            if (flip) rows[er_c][ec_c] <= ~rows[er_c][ec_c];
         end
         if (fin) begin
            row_syn <= '0;
            col_syn <= '0;
            st <= '0;
            er <= '0;
            ec <= '0;
         end
      end
   assign bus.in_ready = state == S_LOAD;
   assign bus.out_valid = state == S_DRAIN;
   assign bus.out_data = bus.out_valid ? rows[cnt] : '0;
   assign bus.out_last = bus.out_valid && last;
   assign bus.err_det = st.det;
   assign bus.err_corr = st.corr;
   assign bus.err_uncorr = st.uncorr;
   assign bus.err_row = er;
   assign bus.err_col = ec;
`ifdef FEC_DEC_STATS_EN
   always_ff @(posedge clk)
      if (rst || clr_stats) begin
         cnt_corr <= '0;
         cnt_uncorr <= '0;
      end else if (state == S_EVAL) begin
         if (st_c.corr && cnt_corr != '1) cnt_corr <= cnt_corr + 1'b1;
         if (st_c.uncorr && cnt_uncorr != '1) cnt_uncorr <= cnt_uncorr + 1'b1;
      end
`endif
endmodule

// File: tb/tb_fec_stream_decoder.sv
// tb_fec_stream_decoder: directed block vectors against hand-computed corrections and status
module tb_fec_stream_decoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   fec_stream_decoder_if #(.WIDTH(4), .DEPTH(4)) bus ();
`ifdef FEC_DEC_STATS_EN
   logic clr_stats = 1'b0;
   logic [1:0] cnt_corr, cnt_uncorr;
`endif
   fec_stream_decoder #(.WIDTH(4), .DEPTH(4), .CNT_W(2)) dut (
      .clk(clk),
      .rst(rst),
`ifdef FEC_DEC_STATS_EN
      .clr_stats(clr_stats),
      .cnt_corr(cnt_corr),
      .cnt_uncorr(cnt_uncorr),
`endif
      .bus(bus)
   );
   int tests = 0;
   int fails = 0;

   task automatic send(input logic [0:3][3:0] d, input logic [0:3] rp, input logic [3:0] cp, input int n);
      int w;
      for (int i = 0; i < n; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data = d[i];
         bus.in_row_par = rp[i];
         bus.in_col_par = (i == 3) ? cp : ~cp;
         w = 0;
         while (!bus.in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
         end
         if (w == 20) begin
            tests++;
            fails++;
            $display("FAIL send_timeout beat %0d in_ready stayed 0", i);
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      bus.in_data = 4'b1010;
      bus.in_row_par = 1'b1;
   endtask

   task automatic collect(output logic [0:3][3:0] d, output logic [0:3] l, output logic [2:0] f,
                          output logic [1:0] er, output logic [1:0] ec, output bit ok);
      int w;
      ok = 1'b1;
      d = '0;
      l = '0;
      f = '0;
      er = '0;
      ec = '0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         w = 0;
         while (!bus.out_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
         end
         if (w == 20) begin
            ok = 1'b0;
            break;
         end
         d[i] = bus.out_data;
         l[i] = bus.out_last;
         if (i == 0) begin
            f = {bus.err_det, bus.err_corr, bus.err_uncorr};
            er = bus.err_row;
            ec = bus.err_col;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({bus.out_valid, bus.out_last, bus.out_data, bus.err_det, bus.err_corr, bus.err_uncorr, bus.err_row, bus.err_col} !== 15'b0) begin
         fails++;
         $display("FAIL reset_outputs valid=%b last=%b data=%b flags=%b%b%b row=%0d col=%0d want all 0",
                  bus.out_valid, bus.out_last, bus.out_data, bus.err_det, bus.err_corr, bus.err_uncorr, bus.err_row, bus.err_col);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (bus.in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
      end
`ifdef FEC_DEC_STATS_EN
      tests++;
      if ({cnt_corr, cnt_uncorr} !== 4'b0) begin
         fails++;
         $display("FAIL reset_counters got %0d/%0d want 0/0", cnt_corr, cnt_uncorr);
      end
`endif
   endtask

   task automatic test_clean;
      logic [0:3][3:0] d; logic [0:3] l; logic [2:0] f; logic [1:0] er, ec; bit ok;
      send({4'b1111, 4'b1111, 4'b1111, 4'b1111}, 4'b0000, 4'b0000, 4);
      tests++;
      if (bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL eval_cycle out_valid=%b want 0", bus.out_valid);
      end
      @(posedge clk); #1;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         fails++;
         $display("FAIL drain_start out_valid=%b in_ready=%b want 1/0", bus.out_valid, bus.in_ready);
      end
      collect(d, l, f, er, ec, ok);
      tests++;
      if (!ok || d !== 16'hFFFF) begin
         fails++;
         $display("FAIL clean_data got %h ok=%b want ffff", d, ok);
      end
      tests++;
      if (l !== 4'b0001) begin
         fails++;
         $display("FAIL clean_last got %b want 0001", l);
      end
      tests++;
      if ({f, er, ec} !== 7'b0) begin
         fails++;
         $display("FAIL clean_status flags=%b row=%0d col=%0d want 000/0/0", f, er, ec);
      end
   endtask

   task automatic test_single_bit;
      logic [0:3][3:0] d; logic [0:3] l; logic [2:0] f; logic [1:0] er, ec; bit ok;
      send({4'b1111, 4'b1111, 4'b1111, 4'b1110}, 4'b0000, 4'b0000, 4);
      collect(d, l, f, er, ec, ok);
      tests++;
      if (!ok || d !== 16'hFFFF || {f, er, ec} !== 7'b110_11_00) begin
         fails++;
         $display("FAIL single_r3c0 data=%h flags=%b row=%0d col=%0d want ffff 110 3 0", d, f, er, ec);
      end
      send({4'b1111, 4'b1011, 4'b1111, 4'b1111}, 4'b0000, 4'b0000, 4);
      collect(d, l, f, er, ec, ok);
      tests++;
      if (!ok || d !== 16'hFFFF || {f, er, ec} !== 7'b110_01_10) begin
         fails++;
         $display("FAIL single_r1c2 data=%h flags=%b row=%0d col=%0d want ffff 110 1 2", d, f, er, ec);
      end
   endtask

   task automatic test_parity_err;
      logic [0:3][3:0] d; logic [0:3] l; logic [2:0] f; logic [1:0] er, ec; bit ok;
      send({4'b1111, 4'b1111, 4'b1111, 4'b1111}, 4'b0010, 4'b0000, 4);
      collect(d, l, f, er, ec, ok);
      tests++;
      if (!ok || d !== 16'hFFFF || {f, er, ec} !== 7'b110_00_00) begin
         fails++;
         $display("FAIL row_par_err data=%h flags=%b row=%0d col=%0d want ffff 110 0 0", d, f, er, ec);
      end
      send({4'b0000, 4'b0000, 4'b0000, 4'b0000}, 4'b0000, 4'b0100, 4);
      collect(d, l, f, er, ec, ok);
      tests++;
      if (!ok || d !== 16'h0000 || {f, er, ec} !== 7'b110_00_00) begin
         fails++;
         $display("FAIL col_par_err data=%h flags=%b row=%0d col=%0d want 0000 110 0 0", d, f, er, ec);
      end
   endtask

   task automatic test_uncorr;
      logic [0:3][3:0] d; logic [0:3] l; logic [2:0] f; logic [1:0] er, ec; bit ok;
      send({4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'b0000, 4'b0000, 4);
      collect(d, l, f, er, ec, ok);
      tests++;
      if (!ok || d !== 16'h7BDE || {f, er, ec} !== 7'b101_00_00) begin
         fails++;
         $display("FAIL uncorr data=%h flags=%b row=%0d col=%0d want 7bde 101 0 0", d, f, er, ec);
      end
`ifdef FEC_DEC_STATS_EN
      tests++;
      if (cnt_uncorr !== 2'd1) begin
         fails++;
         $display("FAIL uncorr_count got %0d want 1", cnt_uncorr);
      end
`endif
   endtask

   task automatic test_back_to_back;
      logic [0:3][3:0] d; logic [0:3] l; logic [2:0] f; logic [1:0] er, ec; bit ok;
      int w;
      send({4'b0001, 4'b0010, 4'b0100, 4'b1000}, 4'b1111, 4'b1111, 4);
      bus.out_ready = 1'b1;
      w = 0;
      while (!bus.out_valid && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 4'b0010 || bus.out_last !== 1'b0 || bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall_hold cyc %0d valid=%b data=%b last=%b in_ready=%b want 1 0010 0 0",
                     k, bus.out_valid, bus.out_data, bus.out_last, bus.in_ready);
         end
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      tests++;
      if (bus.out_data !== 4'b1000 || bus.out_last !== 1'b1) begin
         fails++;
         $display("FAIL stall_tail data=%b last=%b want 1000 1", bus.out_data, bus.out_last);
      end
      @(posedge clk); #1;
      tests++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reload in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
      end
      send({4'b0011, 4'b0101, 4'b0110, 4'b1001}, 4'b0000, 4'b1001, 4);
      collect(d, l, f, er, ec, ok);
      tests++;
      if (!ok || d !== 16'h3569 || f !== 3'b000) begin
         fails++;
         $display("FAIL next_block data=%h flags=%b want 3569 000", d, f);
      end
   endtask

   task automatic test_reset_mid;
      logic [0:3][3:0] d; logic [0:3] l; logic [2:0] f; logic [1:0] er, ec; bit ok;
      bit seen;
      send({4'b0001, 4'b0011, 4'b0000, 4'b0000}, 4'b0110, 4'b0000, 2);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      send({4'b1111, 4'b1011, 4'b1111, 4'b1111}, 4'b0000, 4'b0000, 4);
      collect(d, l, f, er, ec, ok);
      tests++;
      if (!ok || d !== 16'hFFFF || {f, er, ec} !== 7'b110_01_10) begin
         fails++;
         $display("FAIL rst_load_discard data=%h flags=%b row=%0d col=%0d want ffff 110 1 2", d, f, er, ec);
      end
      send({4'b1111, 4'b1111, 4'b1111, 4'b1111}, 4'b0000, 4'b0000, 4);
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         fails++;
         $display("FAIL rst_drain out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
      end
      rst = 1'b0;
      bus.out_ready = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen = 1'b1;
      end
      tests++;
      if (seen) begin
         fails++;
         $display("FAIL rst_drain_quiet out_valid seen=1 want 0");
      end
   endtask

`ifdef FEC_DEC_STATS_EN
   task automatic test_stats;
      logic [0:3][3:0] d; logic [0:3] l; logic [2:0] f; logic [1:0] er, ec; bit ok;
      repeat (5) begin
         send({4'b1111, 4'b1111, 4'b1111, 4'b1110}, 4'b0000, 4'b0000, 4);
         collect(d, l, f, er, ec, ok);
      end
      tests++;
      if (cnt_corr !== 2'd3 || cnt_uncorr !== 2'd0) begin
         fails++;
         $display("FAIL stats_saturate got %0d/%0d want 3/0", cnt_corr, cnt_uncorr);
      end
      send({4'b1111, 4'b1111, 4'b1111, 4'b1110}, 4'b0000, 4'b0000, 4);
      clr_stats = 1'b1;
      @(posedge clk); #1;
      clr_stats = 1'b0;
      tests++;
      if (cnt_corr !== 2'd0) begin
         fails++;
         $display("FAIL stats_clear got %0d want 0", cnt_corr);
      end
      collect(d, l, f, er, ec, ok);
   endtask
`endif

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.in_row_par = 1'b0;
      bus.in_col_par = '0;
      bus.out_ready = 1'b0;
      test_reset;
      test_clean;
      test_single_bit;
      test_parity_err;
      test_uncorr;
      test_back_to_back;
      test_reset_mid;
`ifdef FEC_DEC_STATS_EN
      test_stats;
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
